// File: rtl/mem_bus_if.sv
// MEM-stage bus interface: SPM accesses are served in the same cycle, everything
// else goes over the shared system bus with a req/grant/ready handshake.
module mem_bus_if #(
  parameter int         WORD_ADDR_W = 30,
  parameter int         WORD_DATA_W = 32,
  parameter logic [2:0] SPM_SEG     = 3'b011
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  input  logic [WORD_DATA_W-1:0] spm_rd_data,
  output logic [WORD_ADDR_W-1:0] spm_addr,
  output logic                   spm_as_,
  output logic                   spm_rw,
  output logic [WORD_DATA_W-1:0] spm_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  input  logic                   bus_grnt_,
  output logic                   bus_req_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t                 state_q, state_d;
  logic                   bus_req_q, bus_req_d;
  logic                   bus_as_q, bus_as_d;
  logic [WORD_ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic                   bus_rw_q, bus_rw_d;
  logic [WORD_DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [WORD_DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic                   last_rd_q, last_rd_d;

  logic spm_hit;
  logic access;

  assign spm_hit = (addr[WORD_ADDR_W-1 -: 3] == SPM_SEG);
  assign access  = !flush && !as_;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_addr    = bus_addr_q;
  assign bus_rw      = bus_rw_q;
  assign bus_wr_data = bus_wr_data_q;

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    last_rd_d     = last_rd_q;
    rd_data       = '0;
    busy          = 1'b0;
    spm_as_       = 1'b1;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (spm_hit) begin
            spm_as_ = 1'b0;
            rd_data = rw ? spm_rd_data : '0;
          end else begin
            busy          = 1'b1;
            bus_req_d     = 1'b0;
            bus_addr_d    = addr;
            bus_rw_d      = rw;
            bus_wr_data_d = wr_data;
            state_d       = REQ;
          end
        end
      end
      REQ: begin
        busy = 1'b1;
        if (flush) begin
          bus_req_d = 1'b1;
          state_d   = IDLE;
        end else if (!bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // Strobe is a single-cycle pulse; flush cannot abort a started transfer.
        bus_as_d = 1'b1;
        if (bus_rdy_) begin
          busy = 1'b1;
        end else begin
          rd_data       = bus_rw_q ? bus_rd_data : '0;
          bus_req_d     = 1'b1;
          bus_addr_d    = '0;
          bus_rw_d      = 1'b1;
          bus_wr_data_d = '0;
          last_rd_d     = bus_rw_q;
          if (bus_rw_q) rd_buf_d = bus_rd_data;
          state_d = stall ? STALL : IDLE;
        end
      end
      STALL: begin
        // Hold the completed load result while the pipeline is frozen.
        rd_data = last_rd_q ? rd_buf_q : '0;
        if (!stall || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_rw_q      <= 1'b1;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
      last_rd_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      last_rd_q     <= last_rd_d;
    end
  end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Memory-stage bus interface.
- Takes the word-aligned load/store request from the MEM stage and serves it through one of two paths:
  - scratch-pad memory (SPM), single cycle, no stall;
  - shared system bus, using a request/grant/ready handshake.
- Returns read data to the MEM stage, whose result feeds the MEM/WB pipeline register.
- Raises `busy` to stall the pipeline while a bus access is outstanding.

Parameters:
- WORD_ADDR_W, 30, word address width.
- WORD_DATA_W, 32, data width.
- SPM_SEG, 3'b011, value of addr[WORD_ADDR_W-1 -: 3] that selects the SPM path.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- stall  in  1  pipeline stall from the controller.
- flush  in  1  pipeline flush from the controller.
- busy  out  1  bus access in progress; requests a pipeline stall.
- addr  in  WORD_ADDR_W  access word address.
- as_  in  1  access strobe, active-low.
- rw  in  1  1 = read, 0 = write.
- wr_data  in  WORD_DATA_W  store data.
- rd_data  out  WORD_DATA_W  load data to the MEM stage.
- spm_rd_data  in  WORD_DATA_W  SPM read data.
- spm_addr  out  WORD_ADDR_W  SPM address.
- spm_as_  out  1  SPM strobe, active-low.
- spm_rw  out  1  SPM read/write.
- spm_wr_data  out  WORD_DATA_W  SPM write data.
- bus_rd_data  in  WORD_DATA_W  bus read data.
- bus_rdy_  in  1  bus ready, active-low.
- bus_grnt_  in  1  bus grant, active-low.
- bus_req_  out  1  bus request, active-low.
- bus_addr  out  WORD_ADDR_W  bus address.
- bus_as_  out  1  bus strobe, active-low.
- bus_rw  out  1  bus read/write.
- bus_wr_data  out  WORD_DATA_W  bus write data.

Behaviour:
- Reset state, synchronous, wins over all other inputs:
  - state = IDLE; bus_req_ = 1, bus_as_ = 1, bus_addr = 0, bus_rw = 1, bus_wr_data = 0; rd_buf = 0.
  - Reset during REQ/ACCESS abandons the transaction; no completion is reported.
- SPM outputs are combinational pass-throughs: spm_addr = addr, spm_rw = rw, spm_wr_data = wr_data.
- spm_as_ = 0 only when state = IDLE, flush = 0, as_ = 0 and the address is in SPM_SEG.
- Defaults when no active path: rd_data = 0, busy = 0.
- IDLE:
  - flush = 1 or as_ = 1: no action.
  - SPM hit: single-cycle access. rd_data = spm_rd_data if rw = 1, else 0. busy = 0.
  - Bus address: in the same cycle busy = 1. On the next edge:
    - bus_req_ <= 0;
    - latch bus_addr <= addr, bus_rw <= rw, bus_wr_data <= wr_data;
    - go to REQ.
- REQ: busy = 1.
  - flush = 1: bus_req_ <= 1, go to IDLE (abort).
  - Else if bus_grnt_ = 0: bus_as_ <= 0, go to ACCESS.
  - Else hold.
- ACCESS:
  - bus_as_ <= 1 at the next edge, so the strobe lasts exactly one cycle.
  - While bus_rdy_ = 1: busy = 1. flush is ignored; the bus transaction always completes.
  - Cycle with bus_rdy_ = 0:
    - busy = 0;
    - rd_data = bus_rd_data combinationally if bus_rw = 1, else 0;
    - next edge: bus_req_ <= 1, bus_addr/bus_rw/bus_wr_data <= reset values, rd_buf <= bus_rd_data if read;
    - next state = STALL if stall = 1, else IDLE.
- STALL:
  - busy = 0; rd_data = rd_buf if the completed access was a read, else 0.
  - stall = 0 or flush = 1: go to IDLE.
- Bus master handshake:
  - Never asserts bus_as_ without grant.
  - Holds bus_req_ low continuously from REQ entry until the edge after ready.
- Latency:
  - SPM: 0 extra cycles.
  - Bus: minimum 3 cycles (IDLE request, REQ, ACCESS with ready), plus wait states.

Test Plan:
- SPM read, addr = 30'h1800_0004, rw = 1, spm_rd_data = 32'hDEAD_BEEF -> same cycle: rd_data = DEAD_BEEF, busy = 0, spm_as_ = 0, bus_req_ stays 1.
- Bus read, addr = 30'h0000_0010, grant after 2 cycles, ready after 1 wait state, bus_rd_data = 32'h1234_5678 -> checks:
  - bus_req_ low for the whole transaction;
  - bus_as_ low exactly 1 cycle;
  - busy high until the ready cycle;
  - rd_data = 1234_5678 in the ready cycle.
- Bus write, wr_data = 32'hA5A5_0001 -> checks:
  - bus_wr_data = A5A5_0001 and bus_rw = 0 while bus_as_ = 0;
  - rd_data = 0 at completion;
  - outputs return to reset values.
- Read completes with stall = 1 held 3 cycles -> rd_data holds bus value for 3 cycles (STALL), then IDLE with rd_data = 0.
- Flush in REQ (no grant) -> bus_req_ = 1 next cycle, IDLE, no bus_as_ pulse. Flush in ACCESS -> ignored; transaction completes on ready.
- Reset asserted in ACCESS -> next cycle all bus outputs at reset values, busy = 0, state IDLE.
